writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 155 +++++++++++++++
 tb/tb_writeback_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU results and buffered load results onto the
// single register-file write port. Tracks loads in flight with a pending-bit
// scoreboard so decode can stall on a load-use hazard.
//
// Handshake: a result on either input is accepted on a rising edge where its
// valid and the matching ready are both high. Ready depends only on the
// registered buffer occupancy, never on the valid inputs.
module writeback_unit #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd_i,
    input  logic [DATA_WIDTH-1:0]    alu_data_i,
    output logic                     alu_ready_o,
    input  logic                     ld_issue_i,
    input  logic [ADDRESS_WIDTH-1:0] ld_issue_rd_i,
    input  logic                     ld_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] ld_rd_i,
    input  logic [DATA_WIDTH-1:0]    ld_data_i,
    output logic                     ld_ready_o,
    input  logic [ADDRESS_WIDTH-1:0] rs1_i,
    input  logic [ADDRESS_WIDTH-1:0] rs2_i,
    input  logic [ADDRESS_WIDTH-1:0] rd_i,
    output logic                     stall_o,
    output logic                     WE3_o,
    output logic [ADDRESS_WIDTH-1:0] AD3_o,
    output logic [DATA_WIDTH-1:0]    WD3_o,
    output logic                     idle_o
);

    localparam int NREG = 2 ** ADDRESS_WIDTH;
    localparam int PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    // Load-result buffer storage and bookkeeping
    logic [ADDRESS_WIDTH-1:0] rd_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW:0]              count;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;

    // Write-port selection
    logic                     sel_valid;
    logic [ADDRESS_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0]    sel_data;

    // Registered write port; src_fifo_q marks writes that retire a load
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] ad_q;
    logic [DATA_WIDTH-1:0]    wd_q;
    logic                     src_fifo_q;

    logic [NREG-1:0]          pending;
    logic [NREG-1:0]          pending_nxt;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign alu_ready_o = !full;
    assign ld_ready_o  = !full;
    assign push        = ld_valid_i && !full;

    // Arbitration: a full buffer must drain first, otherwise the ALU has priority
    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (full) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_rd    = rd_mem[rd_ptr];
            sel_data  = data_mem[rd_ptr];
        end else if (alu_valid_i) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd_i;
            sel_data  = alu_data_i;
        end else if (!empty) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_rd    = rd_mem[rd_ptr];
            sel_data  = data_mem[rd_ptr];
        end
    end

    // Buffer storage is not reset; occupancy alone decides which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= ld_rd_i;
            data_mem[wr_ptr] <= ld_data_i;
        end
    end

    // Buffer pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Register the selected write; x0 results are consumed without touching the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            ad_q       <= '0;
            wd_q       <= '0;
            src_fifo_q <= 1'b0;
        end else begin
            we_q       <= sel_valid && (sel_rd != '0);
            src_fifo_q <= pop && (sel_rd != '0);
            if (sel_valid && (sel_rd != '0)) begin
                ad_q <= sel_rd;
                wd_q <= sel_data;
            end
        end
    end

    // Scoreboard update: clear on a load write-back, then set so a new issue wins
    always_comb begin
        pending_nxt = pending;
        if (we_q && src_fifo_q) pending_nxt[ad_q] = 1'b0;
        if (ld_issue_i && (ld_issue_rd_i != '0)) pending_nxt[ld_issue_rd_i] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign stall_o = pending[rs1_i] | pending[rs2_i] | pending[rd_i];
    assign idle_o  = empty && (pending == '0) && !we_q;
    assign WE3_o   = we_q;
    assign AD3_o   = ad_q;
    assign WD3_o   = wd_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table-driven directed vectors for writeback_unit, plus a
// hand-written mid-operation reset sequence and a write-port scoreboard.
module tb_writeback_unit;

    localparam int AW = 5;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          alu_valid_i;
    logic [AW-1:0] alu_rd_i;
    logic [DW-1:0] alu_data_i;
    logic          alu_ready_o;
    logic          ld_issue_i;
    logic [AW-1:0] ld_issue_rd_i;
    logic          ld_valid_i;
    logic [AW-1:0] ld_rd_i;
    logic [DW-1:0] ld_data_i;
    logic          ld_ready_o;
    logic [AW-1:0] rs1_i;
    logic [AW-1:0] rs2_i;
    logic [AW-1:0] rd_i;
    logic          stall_o;
    logic          WE3_o;
    logic [AW-1:0] AD3_o;
    logic [DW-1:0] WD3_o;
    logic          idle_o;

    writeback_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .alu_ready_o   (alu_ready_o),
        .ld_issue_i    (ld_issue_i),
        .ld_issue_rd_i (ld_issue_rd_i),
        .ld_valid_i    (ld_valid_i),
        .ld_rd_i       (ld_rd_i),
        .ld_data_i     (ld_data_i),
        .ld_ready_o    (ld_ready_o),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .rd_i          (rd_i),
        .stall_o       (stall_o),
        .WE3_o         (WE3_o),
        .AD3_o         (AD3_o),
        .WD3_o         (WD3_o),
        .idle_o        (idle_o)
    );

    // ---------------- vector records ----------------
    typedef struct {
        logic          alu_v;
        logic [AW-1:0] alu_rd;
        logic [DW-1:0] alu_d;
        logic          iss;
        logic [AW-1:0] iss_rd;
        logic          ld_v;
        logic [AW-1:0] ld_rd;
        logic [DW-1:0] ld_d;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          e_alu_rdy;
        logic          e_ld_rdy;
        logic          e_stall;
        logic          e_idle;
        logic          e_we;
        logic [AW-1:0] e_ad;
        logic [DW-1:0] e_wd;
    } vec_t;

    function automatic vec_t mk(input int av, input int ard, input int ad,
                                input int iv, input int ird,
                                input int lv, input int lrd, input int ld,
                                input int r1, input int r2, input int r3,
                                input int ear, input int elr, input int est, input int eid,
                                input int ewe, input int ead, input int ewd);
        vec_t v;
        v.alu_v = 1'(av);  v.alu_rd = 5'(ard); v.alu_d = 32'(ad);
        v.iss   = 1'(iv);  v.iss_rd = 5'(ird);
        v.ld_v  = 1'(lv);  v.ld_rd  = 5'(lrd); v.ld_d  = 32'(ld);
        v.rs1   = 5'(r1);  v.rs2    = 5'(r2);  v.rd    = 5'(r3);
        v.e_alu_rdy = 1'(ear); v.e_ld_rdy = 1'(elr);
        v.e_stall   = 1'(est); v.e_idle   = 1'(eid);
        v.e_we = 1'(ewe); v.e_ad = 5'(ead); v.e_wd = 32'(ewd);
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write seen on the port must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && WE3_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected write", {32'd0, 27'd0, AD3_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("write order", {27'd0, AD3_o, WD3_o}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        alu_valid_i = 0; alu_rd_i = '0; alu_data_i = '0;
        ld_issue_i = 0; ld_issue_rd_i = '0;
        ld_valid_i = 0; ld_rd_i = '0; ld_data_i = '0;
        rs1_i = '0; rs2_i = '0; rd_i = '0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        alu_valid_i = v.alu_v; alu_rd_i = v.alu_rd; alu_data_i = v.alu_d;
        ld_issue_i = v.iss; ld_issue_rd_i = v.iss_rd;
        ld_valid_i = v.ld_v; ld_rd_i = v.ld_rd; ld_data_i = v.ld_d;
        rs1_i = v.rs1; rs2_i = v.rs2; rd_i = v.rd;
        #1;
        check($sformatf("v%0d alu_ready", idx), {63'd0, alu_ready_o}, {63'd0, v.e_alu_rdy});
        check($sformatf("v%0d ld_ready", idx),  {63'd0, ld_ready_o},  {63'd0, v.e_ld_rdy});
        check($sformatf("v%0d stall", idx),     {63'd0, stall_o},     {63'd0, v.e_stall});
        check($sformatf("v%0d idle", idx),      {63'd0, idle_o},      {63'd0, v.e_idle});
        @(posedge clk);
        #1;
        check($sformatf("v%0d WE3", idx), {63'd0, WE3_o}, {63'd0, v.e_we});
        check($sformatf("v%0d AD3", idx), {59'd0, AD3_o}, {59'd0, v.e_ad});
        check($sformatf("v%0d WD3", idx), {32'd0, WD3_o}, {32'd0, v.e_wd});
        if (v.e_we) exp_q.push_back({v.e_ad, v.e_wd});
    endtask

    vec_t tbl[$];

    // Safety bound on total run time
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- main test ----------------
    initial begin
        drive_idle();
        rst_n = 1'b0;

        //     alu v,rd,data        iss      ld v,rd,data         rs1,rs2,rd  ardy,lrdy,stall,idle  we,ad,wd
        // ALU write and single-cycle write pulse
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             0, 0, 0,  1, 1, 0, 1,  0, 0, 0));
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0,   0, 0, 0,             0, 0, 0,  1, 1, 0, 1,  1, 5, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             0, 0, 0,  1, 1, 0, 0,  0, 5, 32'hDEADBEEF));
        // Load hazard on x7
        tbl.push_back(mk(0, 0, 0,            1, 7,   0, 0, 0,             7, 0, 0,  1, 1, 0, 1,  0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             0, 0, 7,  1, 1, 1, 0,  0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0,            0, 0,   1, 7, 32'h12345678,  7, 0, 0,  1, 1, 1, 0,  0, 5, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             7, 0, 0,  1, 1, 1, 0,  1, 7, 32'h12345678));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             7, 0, 0,  1, 1, 1, 0,  0, 7, 32'h12345678));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             7, 0, 0,  1, 1, 0, 1,  0, 7, 32'h12345678));
        // x0 results are consumed silently
        tbl.push_back(mk(1, 0, 32'h11111111, 1, 0,   0, 0, 0,             0, 0, 0,  1, 1, 0, 1,  0, 7, 32'h12345678));
        tbl.push_back(mk(0, 0, 0,            0, 0,   1, 0, 32'h22222222,  0, 0, 0,  1, 1, 0, 1,  0, 7, 32'h12345678));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             0, 0, 0,  1, 1, 0, 0,  0, 7, 32'h12345678));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             0, 0, 0,  1, 1, 0, 1,  0, 7, 32'h12345678));
        // Fill buffer under ALU traffic, then full buffer beats held ALU
        tbl.push_back(mk(1, 20, 32'hA0,      1, 10,  1, 10, 32'h100,      0, 0, 0,  1, 1, 0, 1,  1, 20, 32'hA0));
        tbl.push_back(mk(1, 20, 32'hA1,      1, 11,  1, 11, 32'h101,      0, 0, 0,  1, 1, 0, 0,  1, 20, 32'hA1));
        tbl.push_back(mk(1, 20, 32'hA2,      1, 12,  1, 12, 32'h102,      0, 0, 0,  1, 1, 0, 0,  1, 20, 32'hA2));
        tbl.push_back(mk(1, 20, 32'hA3,      1, 13,  1, 13, 32'h103,      0, 0, 0,  1, 1, 0, 0,  1, 20, 32'hA3));
        tbl.push_back(mk(1, 20, 32'hA4,      0, 0,   0, 0, 0,             10, 13, 0, 0, 0, 1, 0,  1, 10, 32'h100));
        tbl.push_back(mk(1, 20, 32'hA4,      0, 0,   0, 0, 0,             10, 0, 0, 1, 1, 1, 0,  1, 20, 32'hA4));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             10, 0, 0, 1, 1, 0, 0,  1, 11, 32'h101));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             0, 0, 0,  1, 1, 0, 0,  1, 12, 32'h102));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             0, 0, 0,  1, 1, 0, 0,  1, 13, 32'h103));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             13, 0, 0, 1, 1, 1, 0,  0, 13, 32'h103));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             13, 0, 0, 1, 1, 0, 1,  0, 13, 32'h103));
        // Push+pop at occupancy 2; issue of x3 on the edge that clears x3
        tbl.push_back(mk(1, 21, 32'hB0,      1, 3,   1, 3, 32'h300,       0, 0, 0,  1, 1, 0, 1,  1, 21, 32'hB0));
        tbl.push_back(mk(1, 21, 32'hB1,      0, 0,   1, 4, 32'h400,       0, 0, 0,  1, 1, 0, 0,  1, 21, 32'hB1));
        tbl.push_back(mk(0, 0, 0,            0, 0,   1, 5, 32'h500,       0, 0, 0,  1, 1, 0, 0,  1, 3, 32'h300));
        tbl.push_back(mk(0, 0, 0,            1, 3,   0, 0, 0,             3, 0, 0,  1, 1, 1, 0,  1, 4, 32'h400));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             3, 0, 0,  1, 1, 1, 0,  1, 5, 32'h500));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             3, 0, 0,  1, 1, 1, 0,  0, 5, 32'h500));
        tbl.push_back(mk(0, 0, 0,            0, 0,   1, 3, 32'h301,       3, 0, 0,  1, 1, 1, 0,  0, 5, 32'h500));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             3, 0, 0,  1, 1, 1, 0,  1, 3, 32'h301));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             3, 0, 0,  1, 1, 1, 0,  0, 3, 32'h301));
        tbl.push_back(mk(0, 0, 0,            0, 0,   0, 0, 0,             3, 0, 0,  1, 1, 0, 1,  0, 3, 32'h301));
        // Three loads buffered with pending bits, ahead of a mid-operation reset
        tbl.push_back(mk(1, 22, 32'hC0,      1, 8,   1, 8, 32'h800,       0, 0, 0,  1, 1, 0, 1,  1, 22, 32'hC0));
        tbl.push_back(mk(1, 22, 32'hC1,      1, 9,   1, 9, 32'h900,       0, 0, 0,  1, 1, 0, 0,  1, 22, 32'hC1));
        tbl.push_back(mk(1, 22, 32'hC2,      1, 14,  1, 14, 32'hE00,      0, 0, 0,  1, 1, 0, 0,  1, 22, 32'hC2));

        // Reset values while held in reset
        #12;
        check("reset WE3", {63'd0, WE3_o}, 64'd0);
        check("reset AD3", {59'd0, AD3_o}, 64'd0);
        check("reset WD3", {32'd0, WD3_o}, 64'd0);
        check("reset alu_ready", {63'd0, alu_ready_o}, 64'd1);
        check("reset ld_ready", {63'd0, ld_ready_o}, 64'd1);
        check("reset idle", {63'd0, idle_o}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

        // Mid-operation reset: outputs clear immediately, buffered loads discarded
        @(negedge clk);
        drive_idle();
        rs1_i = 5'd8; rs2_i = 5'd9; rd_i = 5'd14;
        #1;
        check("pre-reset stall", {63'd0, stall_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset WE3", {63'd0, WE3_o}, 64'd0);
        check("mid reset AD3", {59'd0, AD3_o}, 64'd0);
        check("mid reset WD3", {32'd0, WD3_o}, 64'd0);
        check("mid reset stall", {63'd0, stall_o}, 64'd0);
        check("mid reset idle", {63'd0, idle_o}, 64'd1);
        check("mid reset alu_ready", {63'd0, alu_ready_o}, 64'd1);
        check("mid reset ld_ready", {63'd0, ld_ready_o}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("in reset WE3", {63'd0, WE3_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 9, 14, 1, 1, 0, 1, 0, 0, 0), 100 + i);

        @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
